// File: rtl/num_serializer_pkg.sv
// Shared types and constants for the number serializer: FSM state encoding and frame line levels.
package num_ser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } ser_state_t;

  localparam int   DATA_BITS  = 4;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/num_serializer_if.sv
// Generator-side bus of the serializer: number/strobe in, serial line and status out.
interface num_serializer_if
  import num_ser_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_BITS-1:0] In;
  logic                 InStrobe;
  logic                 TxReady;
  logic                 TxData;
  logic                 TxActive;
  logic [CNT_W-1:0]     Count;
  logic                 Overflow;

  modport master (
    output In, InStrobe, TxReady,
    input  TxData, TxActive, Count, Overflow
  );

  modport slave (
    input  In, InStrobe, TxReady,
    output TxData, TxActive, Count, Overflow
  );

endinterface

// File: rtl/num_fifo.sv
// Synchronous DEPTH x DATA_BITS FIFO; a push into a full FIFO is accepted only alongside a pop.
module num_fifo
  import num_ser_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CW-1:0]        count_o
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q,  count_d;
  logic                 push_ok,  pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by count/pointers, so stale data is never read.
  always_ff @(posedge Clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/num_serializer.sv
// Buffers strobed 4-bit numbers and sends each as start/data(LSB first)/parity/stop on a serial line.
module num_serializer
  import num_ser_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int BIT_CYCLES = 1,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  num_serializer_if.slave  bus
);

  localparam int HOLD_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(BIT_CYCLES - 1);

  ser_state_t           state_q,  state_d;
  logic [HOLD_W-1:0]    hold_q,   hold_d;
  logic [BIT_W-1:0]     bit_q,    bit_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 parity_q, parity_d;
  logic                 txdata_q, txdata_d;
  logic                 active_q, active_d;
  logic                 ovf_q,    ovf_d;

  logic                 pop;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic [CNT_W-1:0]     fifo_count;
  logic                 can_start, hold_done;

  num_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push_i  (bus.InStrobe),
    .pop_i   (pop),
    .data_i  (bus.In),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign can_start = !fifo_empty && bus.TxReady;
  assign hold_done = (hold_q == LAST_HOLD);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    pop      = 1'b0;

    if (state_q != IDLE) hold_d = hold_done ? '0 : hold_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (can_start) begin
          pop      = 1'b1;
          shift_d  = fifo_data;
          parity_d = ^fifo_data;
          hold_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (hold_done) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (hold_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) state_d = PARITY_EN ? PARITY : STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      PARITY: begin
        if (hold_done) state_d = STOP;
      end
      STOP: begin
        // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
        if (hold_done) begin
          if (can_start) begin
            pop      = 1'b1;
            shift_d  = fifo_data;
            parity_d = ^fifo_data;
            state_d  = START;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txdata_d = START_BIT;
      DATA:    txdata_d = shift_d[0];
      PARITY:  txdata_d = parity_d;
      STOP:    txdata_d = STOP_BIT;
      default: txdata_d = IDLE_LEVEL;
    endcase
    active_d = (state_d != IDLE);
    ovf_d    = ovf_q | (bus.InStrobe && fifo_full && !pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      txdata_q <= IDLE_LEVEL;
      active_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      txdata_q <= txdata_d;
      active_q <= active_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.TxData   = txdata_q;
  assign bus.TxActive = active_q;
  assign bus.Count    = fifo_count;
  assign bus.Overflow = ovf_q;

endmodule
